// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : MEM-stage load/store unit in front of the RAM data port.
//                Issues word address, byte enables and lane-replicated store
//                data, extracts and extends load data across the RAM's
//                1-cycle read latency, and suppresses illegal, out-of-range
//                and misaligned accesses with single-cycle error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic [29:0] d_addr,
  output logic        d_we,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        access_err
);

  // First byte-address bit that must be zero for an in-range access
  localparam int C_RANGE_LSB = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [29:0] r_addr;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic [31:0] r_load_data;
  logic        r_resp_valid;
  logic        r_misalign_err;
  logic        r_access_err;

  logic        w_f3_legal;
  logic        w_range_ok;
  logic        w_misaligned;
  logic        w_req;
  logic        w_access;
  logic        w_mis;
  logic        w_accept;
  logic        w_store;
  logic        w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_ext;

  // Legal funct3 encodings differ between loads and stores
  always_comb begin
    w_f3_legal = 1'b0;
    if (req_we) begin
      w_f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
        default:                                w_f3_legal = 1'b0;
      endcase
    end
  end

  assign w_range_ok   = ((req_addr >> C_RANGE_LSB) == 32'd0);
  assign w_misaligned = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                        ((req_funct3[1:0] == 2'b01) && req_addr[0]);

  // Access errors take priority over misalignment; only IDLE accepts requests
  assign w_req    = (r_state == S_IDLE) && req_valid;
  assign w_access = w_req && (!w_f3_legal || !w_range_ok);
  assign w_mis    = w_req && !w_access && w_misaligned;
  assign w_accept = w_req && !w_access && !w_misaligned;
  assign w_store  = w_accept && req_we;
  assign w_load   = w_accept && !req_we;

  // Byte-lane mask and replicated store data by access size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // RAM port: WAIT keeps the latched load address, otherwise follow the request
  assign d_addr       = (r_state == S_WAIT) ? r_addr : req_addr[31:2];
  assign d_we         = rst_n && w_store;
  assign d_be         = (rst_n && w_accept) ? w_be : 4'b0000;
  assign d_wdata      = w_wdata;
  assign stall        = rst_n && (w_load || (r_state == S_WAIT));
  assign resp_valid   = r_resp_valid && !flush;
  assign load_data    = r_load_data;
  assign misalign_err = r_misalign_err;
  assign access_err   = r_access_err;

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    w_lane_b = d_rdata[7:0];
    case (r_off)
      2'd0:    w_lane_b = d_rdata[7:0];
      2'd1:    w_lane_b = d_rdata[15:8];
      2'd2:    w_lane_b = d_rdata[23:16];
      default: w_lane_b = d_rdata[31:24];
    endcase
    w_lane_h = r_off[1] ? d_rdata[31:16] : d_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane_b[7]}}, w_lane_b};
      3'b001:  w_ext = {{16{w_lane_h[15]}}, w_lane_h};
      3'b100:  w_ext = {24'd0, w_lane_b};
      3'b101:  w_ext = {16'd0, w_lane_h};
      default: w_ext = d_rdata;
    endcase
  end

  // Load sequencing FSM with registered response and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= 30'd0;
      r_off          <= 2'd0;
      r_funct3       <= 3'd0;
      r_load_data    <= 32'd0;
      r_resp_valid   <= 1'b0;
      r_misalign_err <= 1'b0;
      r_access_err   <= 1'b0;
    end else begin
      r_access_err   <= w_access;
      r_misalign_err <= w_mis;
      r_resp_valid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_addr   <= req_addr[31:2];
            r_off    <= req_addr[1:0];
            r_funct3 <= req_funct3;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_load_data  <= w_ext;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a word RAM
//                behind the data port and a byte-array reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic [29:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misalign_err;
  logic        access_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_ld;

  load_store_unit #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .stall(stall),
    .resp_valid(resp_valid), .load_data(load_data),
    .misalign_err(misalign_err), .access_err(access_err)
  );

  always #5 clk = ~clk;

  // Initial RAM contents, shared by the RAM and the reference memory
  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Word RAM with byte enables and 1-cycle registered read
  logic [31:0] ram [0:16383];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int w = 0; w < 16384; w++) ram[w] <= init_word(w);
      ram_loaded <= 1'b1;
    end else begin
      if (d_we)
        for (int i = 0; i < 4; i++)
          if (d_be[i]) ram[d_addr[13:0]][8*i +: 8] <= d_wdata[8*i +: 8];
      d_rdata <= ram[d_addr[13:0]];
    end
  end

  // Reference model: flat little-endian byte memory
  logic [7:0] ref_mem [0:65535];

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = 8'(((1 << nbytes(f3)) - 1) << (a % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % nbytes(f3)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[15:0]) + i];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  // 0 = legal, 1 = access error, 2 = misaligned
  function automatic int err_kind(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic illegal;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (illegal || a >= 32'h0001_0000) return 1;
    if (a % nbytes(f3) != 0) return 2;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle(input logic [31:0] a);
    req_valid = 1'b0; req_addr = a;
    @(negedge clk);
    check("idle_we", d_we, 0);
    check("idle_be", d_be, 0);
    check("idle_stall", stall, 0);
    check("idle_addr", d_addr, a >> 2);
    check("idle_acc", access_err, 0);
    check("idle_mis", misalign_err, 0);
    tick();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(negedge clk);
    check("st_we", d_we, 1);
    check("st_be", d_be, exp_be(f3, a));
    check("st_wdata", d_wdata, exp_wdata(f3, d));
    check("st_addr", d_addr, a >> 2);
    check("st_stall", stall, 0);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[int'(a[15:0]) + i] = d[8*i +: 8];
    tick();
    req_valid = 1'b0;
  endtask

  // mode 0: plain, 1: flush in WAIT, 2: flush in RESP
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int mode);
    logic [31:0] exp;
    exp = ref_load(f3, a);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a; req_wdata = $urandom;
    @(negedge clk);
    check("ld_issue_stall", stall, 1);
    check("ld_issue_we", d_we, 0);
    check("ld_issue_addr", d_addr, a >> 2);
    check("ld_issue_be", d_be, exp_be(f3, a));
    tick();
    @(negedge clk);
    check("ld_wait_stall", stall, 1);
    check("ld_wait_addr", d_addr, a >> 2);
    check("ld_wait_resp", resp_valid, 0);
    if (mode == 1) flush = 1'b1;
    tick();
    flush = 1'b0;
    if (mode == 1) begin
      req_valid = 1'b0;
      @(negedge clk);
      check("ld_fl_resp", resp_valid, 0);
      check("ld_fl_stall", stall, 0);
      check("ld_fl_data", load_data, exp_ld);
      tick();
    end else begin
      if (mode == 2) flush = 1'b1;
      @(negedge clk);
      check("ld_resp_valid", resp_valid, (mode == 2) ? 0 : 1);
      check("ld_resp_stall", stall, 0);
      check("ld_resp_data", load_data, exp);
      exp_ld = exp;
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  task automatic do_err(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int kind);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(negedge clk);
    check("err_we", d_we, 0);
    check("err_stall", stall, 0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("err_access", access_err, (kind == 1) ? 1 : 0);
    check("err_misalign", misalign_err, (kind == 2) ? 1 : 0);
    check("err_resp", resp_valid, 0);
    check("err_stall2", stall, 0);
    tick();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;
    int          r;
    int          k;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int w = 0; w < 16384; w++) begin
      logic [31:0] iw;
      iw = init_word(w);
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = iw[8*i +: 8];
    end
    exp_ld = 32'd0;

    // Reset with a store presented: nothing may reach the RAM
    rst_n = 1'b0; flush = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h1;
    tick(); tick();
    @(negedge clk);
    check("rst_we", d_we, 0);
    check("rst_be", d_be, 0);
    check("rst_stall", stall, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_ld", load_data, 0);
    check("rst_mis", misalign_err, 0);
    check("rst_acc", access_err, 0);
    tick();
    rst_n = 1'b1; req_valid = 1'b0;
    do_idle(32'h40);

    // Word, byte and half round trips with sign/zero extension
    do_store(3'd2, 32'h10, 32'hDEADBEEF);
    do_load(3'd2, 32'h10, 0);
    check("lw_literal", load_data, 32'hDEADBEEF);
    do_store(3'd0, 32'h13, 32'h00000080);
    do_load(3'd0, 32'h13, 0);
    check("lb_literal", load_data, 32'hFFFFFF80);
    do_load(3'd4, 32'h13, 0);
    check("lbu_literal", load_data, 32'h00000080);
    do_store(3'd1, 32'h22, 32'h00008001);
    do_load(3'd1, 32'h22, 0);
    check("lh_literal", load_data, 32'hFFFF8001);
    do_load(3'd5, 32'h22, 0);
    check("lhu_literal", load_data, 32'h00008001);

    // Misaligned and out-of-range / illegal accesses leave memory untouched
    do_err(1'b0, 3'd2, 32'h06, 32'h0, 2);
    do_err(1'b1, 3'd1, 32'h05, 32'h1234, 2);
    do_load(3'd2, 32'h04, 0);
    do_err(1'b0, 3'd2, 32'h0001_0000, 32'h0, 1);
    do_err(1'b0, 3'd3, 32'h10, 32'h0, 1);
    do_err(1'b1, 3'd3, 32'h10, 32'h0, 1);

    // Flush in WAIT and RESP
    do_load(3'd2, 32'h24, 1);
    do_load(3'd2, 32'h10, 2);

    // Reset while a load is waiting on the RAM
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_we", d_we, 0);
    tick();
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("midrst_resp", resp_valid, 0);
    check("midrst_ld", load_data, 0);
    check("midrst_stall2", stall, 0);
    exp_ld = 32'd0;
    tick();

    // Randomized traffic, back-to-back
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        f3 = 3'($urandom_range(0, 2));
        a = $urandom_range(0, 65535);
        a = a & ~(32'(nbytes(f3)) - 1);
        do_store(f3, a, $urandom);
      end else if (r < 75) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        a = $urandom_range(0, 65535);
        a = a & ~(32'(nbytes(f3)) - 1);
        k = $urandom_range(0, 9);
        do_load(f3, a, (k == 0) ? 1 : (k == 1) ? 2 : 0);
      end else if (r < 90) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 65535));
        k = err_kind(we, f3, a);
        if (k != 0) do_err(we, f3, a, $urandom, k);
        else do_idle(a);
      end else begin
        do_idle(32'($urandom_range(0, 65535)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
